clk_gate_ctrl: RTL



---
 rtl/clk_gate_pkg.sv | 21 ++
 rtl/clk_gate_ctrl_if.sv | 26 ++
 rtl/clk_gate_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/clk_gate_pkg.sv
// rtl/clk_gate_pkg.sv - shared state encoding and default timing for the clock-gate controller
package clk_gate_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_OFF  = 3'd0;
  localparam state_t ST_WAKE = 3'd1;
  localparam state_t ST_ON   = 3'd2;
  localparam state_t ST_HOLD = 3'd3;
  localparam state_t ST_COOL = 3'd4;

  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_OFF_MIN     = 2;

  // States in which the gated domain must be clocked.
  function automatic logic state_gates_clk(input state_t s);
    return (s == ST_WAKE) || (s == ST_ON) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// rtl/clk_gate_ctrl_if.sv - client handshake and gate-enable signals of the clock-gate controller
interface clk_gate_ctrl_if;

  logic run_req;
  logic force_on;
  logic gate_en;
  logic run_ack;
  logic busy;

  modport master (
    output run_req,
    output force_on,
    input  gate_en,
    input  run_ack,
    input  busy
  );

  modport slave (
    input  run_req,
    input  force_on,
    output gate_en,
    output run_ack,
    output busy
  );

endinterface

// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - decides when the gated domain runs: wake settle, idle hold, minimum off time
module clk_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int OFF_MIN     = DEF_OFF_MIN,
  parameter int CNT_W       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  clk_gate_ctrl_if.slave bus
);

  if (WAKE_CYCLES < 1 || (WAKE_CYCLES >> CNT_W) != 0) begin : g_bad_wake
    $error("clk_gate_ctrl: WAKE_CYCLES out of range for CNT_W");
  end
  if (HOLD_CYCLES < 0 || (HOLD_CYCLES >> CNT_W) != 0) begin : g_bad_hold
    $error("clk_gate_ctrl: HOLD_CYCLES out of range for CNT_W");
  end
  if (OFF_MIN < 0 || (OFF_MIN >> CNT_W) != 0) begin : g_bad_off
    $error("clk_gate_ctrl: OFF_MIN out of range for CNT_W");
  end

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             gate_en_q, run_ack_q, busy_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : '0;
    case (state)
      ST_OFF: begin
        if (bus.run_req) begin
          state_nxt = ST_WAKE;
          cnt_nxt   = CNT_W'(WAKE_CYCLES - 1);
        end
      end
      ST_WAKE: begin
        // An abandoned wake still passes through HOLD so the clock never gets a runt pulse.
        if (!bus.run_req) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CNT_W'(HOLD_CYCLES);
        end else if (cnt == '0) begin
          state_nxt = ST_ON;
        end
      end
      ST_ON: begin
        if (!bus.run_req) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = CNT_W'(HOLD_CYCLES);
        end
      end
      ST_HOLD: begin
        if (bus.run_req) begin
          state_nxt = ST_ON;
        end else if (cnt == '0) begin
          state_nxt = ST_COOL;
          cnt_nxt   = CNT_W'(OFF_MIN);
        end
      end
      ST_COOL: begin
        if (cnt == '0) begin
          state_nxt = ST_OFF;
        end
      end
      default: begin
        state_nxt = ST_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_OFF;
      cnt       <= '0;
      gate_en_q <= 1'b0;
      run_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gate_en_q <= state_gates_clk(state_nxt) | bus.force_on;
      run_ack_q <= (state_nxt == ST_ON);
      busy_q    <= (state_nxt != ST_OFF);
    end
  end

  assign bus.gate_en = gate_en_q;
  assign bus.run_ack = run_ack_q;
  assign bus.busy    = busy_q;

  a_ack_needs_clock : assert property (@(posedge clk) disable iff (!rst_n) run_ack_q |-> gate_en_q);

endmodule
